pipe_ctrl_hazard: RTL and testbench

- Pipeline-side consumer of the decoded control word produced in ID.
- Carries the control word through ID/EX, EX/MEM and MEM/WB registers.
- Detects data and control hazards, and drives forwarding selects, stall/flush strobes and the EX-stage PC-select for the 5-stage RV32I pipeline.
- Datapath registers and the IF/ID register live outside; this block owns only control-pipeline state and hazard decisions.

---
 rtl/rv_pipe_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 56 +++++
 rtl/pipe_ctrl_hazard.sv | 113 +++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared encodings and control-word type for the RV32I pipeline
package rv_pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational forwarding selects, load-use stall and flush strobes
module hazard_detect
  import rv_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [1:0]      ex_result_src,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_zero,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic            pc_src_e
);

  logic load_stall;
  logic mem_valid;
  logic wb_valid;

  // x0 is hardwired zero, so a write to it never creates a dependency
  assign mem_valid = mem_reg_write && (mem_rd != '0);
  assign wb_valid  = wb_reg_write  && (wb_rd  != '0);

  always_comb begin
    fwd_a_e = FWD_RF;
    if (mem_valid && (mem_rd == ex_rs1))     fwd_a_e = FWD_MEM;
    else if (wb_valid && (wb_rd == ex_rs1))  fwd_a_e = FWD_WB;

    fwd_b_e = FWD_RF;
    if (mem_valid && (mem_rd == ex_rs2))     fwd_b_e = FWD_MEM;
    else if (wb_valid && (wb_rd == ex_rs2))  fwd_b_e = FWD_WB;
  end

  assign load_stall = (ex_result_src == RES_MEM) && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign pc_src_e = (ex_branch && ex_zero) || ex_jump;
  assign stall_f  = load_stall;
  assign stall_d  = load_stall;
  assign flush_d  = pc_src_e;
  assign flush_e  = load_stall || pc_src_e;

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - ID/EX, EX/MEM, MEM/WB control registers plus hazard unit
module pipe_ctrl_hazard
  import rv_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      id_result_src,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [2:0]      id_alu_control,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_zero,
  output logic            ex_alu_src,
  output logic [2:0]      ex_alu_control,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic            mem_mem_write,
  output logic [1:0]      mem_result_src,
  output logic            mem_reg_write,
  output logic [RA_W-1:0] mem_rd,
  output logic [1:0]      wb_result_src,
  output logic            wb_reg_write,
  output logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic            pc_src_e
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;

  assign id_ctrl = '{result_src:  id_result_src,
                     mem_write:   id_mem_write,
                     alu_src:     id_alu_src,
                     reg_write:   id_reg_write,
                     branch:      id_branch,
                     jump:        id_jump,
                     alu_control: id_alu_control};

  // A flush turns the incoming instruction into a bubble rather than holding EX
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      ex_ctrl <= '0;
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_rd   <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_rd   <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_mem_write  <= 1'b0;
      mem_result_src <= RES_ALU;
      mem_reg_write  <= 1'b0;
      mem_rd         <= '0;
      wb_result_src  <= RES_ALU;
      wb_reg_write   <= 1'b0;
      wb_rd          <= '0;
    end else begin
      mem_mem_write  <= ex_ctrl.mem_write;
      mem_result_src <= ex_ctrl.result_src;
      mem_reg_write  <= ex_ctrl.reg_write;
      mem_rd         <= ex_rd;
      wb_result_src  <= mem_result_src;
      wb_reg_write   <= mem_reg_write;
      wb_rd          <= mem_rd;
    end
  end

  assign ex_alu_src     = ex_ctrl.alu_src;
  assign ex_alu_control = ex_ctrl.alu_control;

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_result_src (ex_ctrl.result_src),
    .ex_branch     (ex_ctrl.branch),
    .ex_jump       (ex_ctrl.jump),
    .ex_zero       (ex_zero),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_a_e       (fwd_a_e),
    .fwd_b_e       (fwd_b_e),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .pc_src_e      (pc_src_e)
  );

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb/tb_pipe_ctrl_hazard.sv - directed self-checking bench for pipe_ctrl_hazard
module tb_pipe_ctrl_hazard;

  logic       clk;
  logic       rst_n;
  logic [1:0] id_result_src;
  logic       id_mem_write;
  logic       id_alu_src;
  logic       id_reg_write;
  logic       id_branch;
  logic       id_jump;
  logic [2:0] id_alu_control;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;
  logic       ex_alu_src;
  logic [2:0] ex_alu_control;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_mem_write;
  logic [1:0] mem_result_src;
  logic       mem_reg_write;
  logic [4:0] mem_rd;
  logic [1:0] wb_result_src;
  logic       wb_reg_write;
  logic [4:0] wb_rd;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       stall_f, stall_d, flush_d, flush_e, pc_src_e;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl_hazard #(.RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_result_src(id_result_src), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_control(id_alu_control), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_zero(ex_zero), .ex_alu_src(ex_alu_src), .ex_alu_control(ex_alu_control),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_result_src(wb_result_src), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .pc_src_e(pc_src_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [1:0] rs, input logic rw, input logic mw,
                        input logic br, input logic jp, input logic [2:0] ac,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    id_result_src  = rs;
    id_reg_write   = rw;
    id_mem_write   = mw;
    id_branch      = br;
    id_jump        = jp;
    id_alu_control = ac;
    id_alu_src     = 1'b0;
    id_rd          = rd;
    id_rs1         = r1;
    id_rs2         = r2;
  endtask

  task automatic chk_strobes(input string tag, input logic [7:0] exp_sf, input logic [7:0] exp_fd,
                             input logic [7:0] exp_fe, input logic [7:0] exp_pc);
    chk({tag, "_stall_f"}, 8'(stall_f), exp_sf);
    chk({tag, "_stall_d"}, 8'(stall_d), exp_sf);
    chk({tag, "_flush_d"}, 8'(flush_d), exp_fd);
    chk({tag, "_flush_e"}, 8'(flush_e), exp_fe);
    chk({tag, "_pc_src_e"}, 8'(pc_src_e), exp_pc);
  endtask

  initial begin
    rst_n   = 1'b0;
    ex_zero = 1'b0;
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 5'd0, 5'd0);

    // Reset held two cycles with a live writer in ID
    tick();
    tick();
    chk("rst_ex_rd", 8'(ex_rd), 8'h0);
    chk("rst_mem_reg_write", 8'(mem_reg_write), 8'h0);
    chk("rst_wb_reg_write", 8'(wb_reg_write), 8'h0);
    chk("rst_wb_rd", 8'(wb_rd), 8'h0);
    chk("rst_fwd_a", 8'(fwd_a_e), 8'h0);
    chk("rst_fwd_b", 8'(fwd_b_e), 8'h0);
    chk_strobes("rst", 8'h0, 8'h0, 8'h0, 8'h0);

    rst_n = 1'b1;
    tick();
    chk("rel1_ex_rd", 8'(ex_rd), 8'h5);
    chk("rel1_wb_reg_write", 8'(wb_reg_write), 8'h0);
    tick();
    chk("rel2_mem_reg_write", 8'(mem_reg_write), 8'h1);
    chk("rel2_wb_reg_write", 8'(wb_reg_write), 8'h0);
    tick();
    chk("rel3_wb_reg_write", 8'(wb_reg_write), 8'h1);
    chk("rel3_wb_rd", 8'(wb_rd), 8'h5);

    // Mid-operation reset with a store in flight
    set_id(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd1, 5'd2);
    tick();
    tick();
    chk("pre_mid_mem_write", 8'(mem_mem_write), 8'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wb_reg_write", 8'(wb_reg_write), 8'h0);
    chk("mid_rst_mem_mem_write", 8'(mem_mem_write), 8'h0);
    rst_n = 1'b1;

    // add x5 then dependent sub: MEM forward on A
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 5'd1, 5'd2);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 5'd6, 5'd5, 5'd3);
    tick();
    chk("fwd_mem_a", 8'(fwd_a_e), 8'h2);
    chk("fwd_mem_b", 8'(fwd_b_e), 8'h0);
    chk("ex_alu_control", 8'(ex_alu_control), 8'h5);
    // One instruction between producer and consumer: WB forward
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd8, 5'd5, 5'd0);
    tick();
    chk("fwd_wb_a", 8'(fwd_a_e), 8'h1);
    chk("fwd_wb_b", 8'(fwd_b_e), 8'h0);

    // Both MEM and WB write x9: MEM wins
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9, 5'd1, 5'd1);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9, 5'd2, 5'd2);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd10, 5'd9, 5'd9);
    tick();
    chk("fwd_prio_a", 8'(fwd_a_e), 8'h2);
    chk("fwd_prio_b", 8'(fwd_b_e), 8'h2);

    // Load-use on rs2
    set_id(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd7, 5'd1, 5'd0);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd11, 5'd3, 5'd7);
    #1;
    chk_strobes("lu", 8'h1, 8'h0, 8'h1, 8'h0);
    tick();
    chk("lu_bubble_ex_rd", 8'(ex_rd), 8'h0);
    chk("lu_mem_result_src", 8'(mem_result_src), 8'h1);
    chk_strobes("lu_after", 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    chk("lu_ex_rd", 8'(ex_rd), 8'hb);
    chk("lu_fwd_b", 8'(fwd_b_e), 8'h1);
    chk("lu_wb_result_src", 8'(wb_result_src), 8'h1);

    // Taken branch
    set_id(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd1, 5'd2);
    tick();
    ex_zero = 1'b1;
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd12, 5'd0, 5'd0);
    #1;
    chk_strobes("br_taken", 8'h0, 8'h1, 8'h1, 8'h1);
    tick();
    chk("br_bubble_ex_rd", 8'(ex_rd), 8'h0);
    // Not-taken branch
    ex_zero = 1'b0;
    set_id(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd1, 5'd2);
    tick();
    set_id(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk_strobes("br_not_taken", 8'h0, 8'h0, 8'h0, 8'h0);

    // Load to x0 never stalls or forwards
    set_id(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd1, 5'd0);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd13, 5'd0, 5'd4);
    #1;
    chk_strobes("x0", 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    chk("x0_fwd_a", 8'(fwd_a_e), 8'h0);
    chk("x0_mem_reg_write", 8'(mem_reg_write), 8'h1);

    // Jump in EX that also looks like a load to x14 feeding ID
    set_id(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 5'd14, 5'd0, 5'd0);
    tick();
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd16, 5'd14, 5'd0);
    #1;
    chk_strobes("sim", 8'h1, 8'h1, 8'h1, 8'h1);
    tick();
    chk("sim_bubble_ex_rd", 8'(ex_rd), 8'h0);
    chk_strobes("sim_after", 8'h0, 8'h0, 8'h0, 8'h0);
    set_id(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd15, 5'd0, 5'd0);
    tick();
    chk("sim_next_ex_rd", 8'(ex_rd), 8'hf);
    chk("sim_mem_rd", 8'(mem_rd), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
